// File: rtl/quant_param_bank.sv
`default_nettype none
// ============================================================================
// Module      : quant_param_bank
// Description : Double-buffered, run-time writable table of per-layer
//               requantization parameters (multiplier, shift, zero point).
//               The host fills the inactive bank and swaps banks with a
//               single commit pulse. The datapath reads the active bank
//               through a 2-cycle pipelined port that flags never-written
//               entries (rd_miss) and out-of-range indices (rd_err).
// Revision    : 1.0 - initial release
// ============================================================================
module quant_param_bank #(
    parameter int LAYERS  = 29,
    parameter int LAYER_W = 5,
    parameter int MULT_W  = 32,
    parameter int SHIFT_W = 6,
    parameter int ZP_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,

    // Host configuration port
    input  logic               cfg_we,
    input  logic [LAYER_W-1:0] cfg_layer,
    input  logic [MULT_W-1:0]  cfg_mult,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [ZP_W-1:0]    cfg_zp,
    input  logic               cfg_commit,
    output logic               cfg_err,
    output logic               active_bank,

    // Datapath read port
    input  logic               rd_req,
    input  logic [LAYER_W-1:0] rd_layer,
    output logic               rd_valid,
    output logic [MULT_W-1:0]  mult_scalar,
    output logic [SHIFT_W-1:0] shift_scalar,
    output logic [ZP_W-1:0]    zp_out,
    output logic               rd_miss,
    output logic               rd_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Entry count widened by one bit so an all-ones index compares cleanly.
    localparam logic [LAYER_W:0]  c_layers   = (LAYER_W+1)'(LAYERS);
    // Identity requantization: multiply by one, no shift, no offset.
    localparam logic [MULT_W-1:0] c_id_mult  = MULT_W'(1);
    localparam logic [SHIFT_W-1:0] c_id_shift = '0;
    localparam logic [ZP_W-1:0]   c_id_zp    = '0;

    // ------------------------------------------------------------------------
    // Storage: two banks of LAYERS entries, plus per-entry written flags
    // ------------------------------------------------------------------------
    logic [MULT_W-1:0]  r_mult    [2][LAYERS];
    logic [SHIFT_W-1:0] r_shift   [2][LAYERS];
    logic [ZP_W-1:0]    r_zp      [2][LAYERS];
    logic [LAYERS-1:0]  r_written [2];

    // ------------------------------------------------------------------------
    // Write-side decode
    // ------------------------------------------------------------------------
    logic w_cfg_in_range;
    logic w_cfg_wr;
    logic w_cfg_bad;
    logic w_wr_bank;

    assign w_cfg_in_range = ({1'b0, cfg_layer} < c_layers);
    assign w_cfg_wr       = cfg_we &  w_cfg_in_range;
    assign w_cfg_bad      = cfg_we & ~w_cfg_in_range;
    // Writes always land in the bank that is inactive before any same-cycle
    // commit, so a write+commit pair becomes visible right after the swap.
    assign w_wr_bank      = ~active_bank;

    // ------------------------------------------------------------------------
    // Read pipeline registers
    // ------------------------------------------------------------------------
    logic               r_s1_valid;
    logic [LAYER_W-1:0] r_s1_layer;
    logic               r_s1_bank;
    logic               r_s1_oor;

    logic [LAYER_W-1:0] w_rd_idx;
    logic               w_rd_written;

    // Out-of-range indices are steered to entry 0 so the array is never
    // addressed past its end; the result is replaced by identity anyway.
    assign w_rd_idx     = r_s1_oor ? '0 : r_s1_layer;
    assign w_rd_written = r_written[r_s1_bank][w_rd_idx];

    // Active bank toggles on each commit pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_bank <= 1'b0;
        end else if (cfg_commit) begin
            active_bank <= ~active_bank;
        end
    end

    // Dropped write pulses cfg_err for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= w_cfg_bad;
        end
    end

    // Written flags are the only part of the table that needs reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_written[0] <= '0;
            r_written[1] <= '0;
        end else if (w_cfg_wr) begin
            r_written[w_wr_bank][cfg_layer] <= 1'b1;
        end
    end

    // Entry payload store; contents are qualified by the written flags.
    always_ff @(posedge clk) begin
        if (w_cfg_wr) begin
            r_mult [w_wr_bank][cfg_layer] <= cfg_mult;
            r_shift[w_wr_bank][cfg_layer] <= cfg_shift;
            r_zp   [w_wr_bank][cfg_layer] <= cfg_zp;
        end
    end

    // Stage 1: capture the request together with the bank active right now,
    // so a later commit cannot redirect a read already accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_layer <= '0;
            r_s1_bank  <= 1'b0;
            r_s1_oor   <= 1'b0;
        end else begin
            r_s1_valid <= rd_req;
            if (rd_req) begin
                r_s1_layer <= rd_layer;
                r_s1_bank  <= active_bank;
                r_s1_oor   <= ~({1'b0, rd_layer} < c_layers);
            end
        end
    end

    // Stage 2: look up the captured entry and register the result; data
    // outputs hold between results while the status flags return to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid     <= 1'b0;
            rd_miss      <= 1'b0;
            rd_err       <= 1'b0;
            mult_scalar  <= '0;
            shift_scalar <= '0;
            zp_out       <= '0;
        end else if (r_s1_valid) begin
            rd_valid <= 1'b1;
            if (r_s1_oor) begin
                rd_err       <= 1'b1;
                rd_miss      <= 1'b0;
                mult_scalar  <= c_id_mult;
                shift_scalar <= c_id_shift;
                zp_out       <= c_id_zp;
            end else if (!w_rd_written) begin
                rd_err       <= 1'b0;
                rd_miss      <= 1'b1;
                mult_scalar  <= c_id_mult;
                shift_scalar <= c_id_shift;
                zp_out       <= c_id_zp;
            end else begin
                rd_err       <= 1'b0;
                rd_miss      <= 1'b0;
                mult_scalar  <= r_mult [r_s1_bank][w_rd_idx];
                shift_scalar <= r_shift[r_s1_bank][w_rd_idx];
                zp_out       <= r_zp   [r_s1_bank][w_rd_idx];
            end
        end else begin
            rd_valid <= 1'b0;
            rd_miss  <= 1'b0;
            rd_err   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quant_param_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_quant_param_bank
// Description : Scoreboard bench for quant_param_bank. A reference model of
//               both banks predicts each read result at issue time; the
//               prediction is queued and compared when rd_valid appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quant_param_bank;

    localparam int LAYERS  = 29;
    localparam int LAYER_W = 5;
    localparam int MULT_W  = 32;
    localparam int SHIFT_W = 6;
    localparam int ZP_W    = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_we;
    logic [LAYER_W-1:0] cfg_layer;
    logic [MULT_W-1:0]  cfg_mult;
    logic [SHIFT_W-1:0] cfg_shift;
    logic [ZP_W-1:0]    cfg_zp;
    logic               cfg_commit;
    logic               cfg_err;
    logic               active_bank;
    logic               rd_req;
    logic [LAYER_W-1:0] rd_layer;
    logic               rd_valid;
    logic [MULT_W-1:0]  mult_scalar;
    logic [SHIFT_W-1:0] shift_scalar;
    logic [ZP_W-1:0]    zp_out;
    logic               rd_miss;
    logic               rd_err;

    quant_param_bank #(
        .LAYERS (LAYERS),
        .LAYER_W(LAYER_W),
        .MULT_W (MULT_W),
        .SHIFT_W(SHIFT_W),
        .ZP_W   (ZP_W)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_layer   (cfg_layer),
        .cfg_mult    (cfg_mult),
        .cfg_shift   (cfg_shift),
        .cfg_zp      (cfg_zp),
        .cfg_commit  (cfg_commit),
        .cfg_err     (cfg_err),
        .active_bank (active_bank),
        .rd_req      (rd_req),
        .rd_layer    (rd_layer),
        .rd_valid    (rd_valid),
        .mult_scalar (mult_scalar),
        .shift_scalar(shift_scalar),
        .zp_out      (zp_out),
        .rd_miss     (rd_miss),
        .rd_err      (rd_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model
    logic [MULT_W-1:0]  m_mult  [2][LAYERS];
    logic [SHIFT_W-1:0] m_shift [2][LAYERS];
    logic [ZP_W-1:0]    m_zp    [2][LAYERS];
    bit                 m_wr    [2][LAYERS];
    bit                 m_act;

    typedef struct {
        int                 due;
        logic [MULT_W-1:0]  mult;
        logic [SHIFT_W-1:0] shift;
        logic [ZP_W-1:0]    zp;
        logic               miss;
        logic               err;
    } exp_t;

    exp_t sb[$];

    logic [MULT_W-1:0]  last_mult  = '0;
    logic [SHIFT_W-1:0] last_shift = '0;
    logic [ZP_W-1:0]    last_zp    = '0;

    task automatic model_clear();
        for (int b = 0; b < 2; b++)
            for (int l = 0; l < LAYERS; l++)
                m_wr[b][l] = 1'b0;
        m_act = 1'b0;
    endtask

    // One clock cycle of stimulus. Called 1ns after a rising edge.
    task automatic step(input logic we, input logic [LAYER_W-1:0] wl,
                        input logic [MULT_W-1:0] wm, input logic [SHIFT_W-1:0] ws,
                        input logic [ZP_W-1:0] wz, input logic commit,
                        input logic req, input logic [LAYER_W-1:0] rl);
        exp_t e;
        int   wb;
        logic exp_cerr;
        cfg_we = we; cfg_layer = wl; cfg_mult = wm; cfg_shift = ws; cfg_zp = wz;
        cfg_commit = commit; rd_req = req; rd_layer = rl;
        if (req) begin
            e.due = cyc + 2;
            if (int'(rl) >= LAYERS) begin
                e.mult = 1; e.shift = 0; e.zp = 0; e.miss = 0; e.err = 1;
            end else if (!m_wr[m_act][rl]) begin
                e.mult = 1; e.shift = 0; e.zp = 0; e.miss = 1; e.err = 0;
            end else begin
                e.mult = m_mult[m_act][rl]; e.shift = m_shift[m_act][rl];
                e.zp = m_zp[m_act][rl]; e.miss = 0; e.err = 0;
            end
            sb.push_back(e);
        end
        exp_cerr = we && (int'(wl) >= LAYERS);
        if (we && int'(wl) < LAYERS) begin
            wb = m_act ? 0 : 1;
            m_mult[wb][wl] = wm; m_shift[wb][wl] = ws; m_zp[wb][wl] = wz;
            m_wr[wb][wl] = 1'b1;
        end
        if (commit) m_act = ~m_act;
        @(posedge clk);
        #1;
        check("cfg_err", cfg_err, exp_cerr);
        check("active_bank", active_bank, m_act);
        cfg_we = 0; cfg_commit = 0; rd_req = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [LAYER_W-1:0] l);
        step(0, 0, 0, 0, 0, 0, 1, l);
    endtask

    task automatic wr(input logic [LAYER_W-1:0] l, input logic [MULT_W-1:0] m,
                      input logic [SHIFT_W-1:0] s, input logic [ZP_W-1:0] z);
        step(1, l, m, s, z, 0, 0, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, rd_valid, 0);
        check({tag, "_miss"}, rd_miss, 0);
        check({tag, "_err"}, rd_err, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
        check({tag, "_mult"}, mult_scalar, 0);
        check({tag, "_shift"}, shift_scalar, 0);
        check({tag, "_zp"}, zp_out, 0);
        check({tag, "_bank"}, active_bank, 0);
    endtask

    // Output monitor: pops one prediction per rd_valid, otherwise checks
    // that flags are low and data outputs hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_mult  = '0;
            last_shift = '0;
            last_zp    = '0;
        end else if (rd_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", rd_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_latency", cyc, e.due);
                check("mult", mult_scalar, e.mult);
                check("shift", shift_scalar, e.shift);
                check("zp", zp_out, e.zp);
                check("rd_miss", rd_miss, e.miss);
                check("rd_err", rd_err, e.err);
                last_mult  = e.mult;
                last_shift = e.shift;
                last_zp    = e.zp;
            end
        end else begin
            check("idle_miss", rd_miss, 0);
            check("idle_err", rd_err, 0);
            check("hold_mult", mult_scalar, last_mult);
            check("hold_shift", shift_scalar, last_shift);
            check("hold_zp", zp_out, last_zp);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        cfg_we = 0; cfg_layer = 0; cfg_mult = 0; cfg_shift = 0; cfg_zp = 0;
        cfg_commit = 0; rd_req = 0; rd_layer = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Fresh table: identity with rd_miss
        rd(0);
        idle(2);

        // Write to inactive bank is invisible until commit
        wr(0, 32'd1499917960, 6'd36, 8'h97);
        rd(0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        rd(0);
        idle(2);

        // Write + commit in one cycle, with a read in that same cycle
        step(1, 5, 32'd2080045790, 6'd35, 8'hA0, 1, 1, 5);
        rd(5);
        idle(2);

        // Read accepted, then commit the following cycle: old bank is used
        wr(7, 32'h8000_0001, 6'd63, 8'h80);
        rd(7);
        step(0, 0, 0, 0, 0, 1, 1, 7);
        rd(7);
        idle(2);

        // Fill layers 0..3, commit, back-to-back reads
        for (int i = 0; i < 4; i++) wr(i[LAYER_W-1:0], 32'h1000_0000 + i, 6'(i + 1), 8'(8'hF0 + i));
        step(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) rd(i[LAYER_W-1:0]);
        idle(3);

        // Explicit identity entry reads with rd_miss=0
        wr(28, 32'd1, 6'd0, 8'd0);
        step(0, 0, 0, 0, 0, 1, 1, 28);
        rd(28);
        idle(2);

        // Out-of-range writes and reads
        wr(30, 32'hDEAD_BEEF, 6'd9, 8'd9);
        wr(31, 32'hDEAD_BEEF, 6'd9, 8'd9);
        wr(29, 32'hDEAD_BEEF, 6'd9, 8'd9);
        rd(31);
        rd(29);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < LAYERS; i++) rd(i[LAYER_W-1:0]);
        idle(3);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 6'($urandom), 8'($urandom), ($urandom_range(0, 11) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end
        idle(3);
        check("sb_drained", sb.size(), 0);

        // Reset in the middle of a read
        rd(3);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        sb.delete();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        for (int i = 0; i < LAYERS; i++) rd(i[LAYER_W-1:0]);
        idle(3);
        check("sb_final", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
